mdr_in_ctrl: RTL
================

// Module: mdr_in_ctrl
// PURPOSE
//  Read-side Memory Data Register: complement of the MDR write/output path.
//  Requests a word from memory on control-unit command, captures it on valid,
//  holds it, and drives it onto the internal 16-bit bus when enabled.
//  Sits between the memory read port and the CPU data bus. A wait timer
//  aborts reads that memory never answers.
// PARAMETERS
//  DATA_W       16  width of memory word, MDR and bus
//  TIMEOUT_CYC   8  WAIT cycles without mem_rd_valid before abort (>=2)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  rd_start       in   1       control unit: begin memory read
//  mdr_clr        in   1       control unit: discard held word, go IDLE
//  mem_rd_req     out  1       read request to memory, high throughout WAIT
//  mem_rd_valid   in   1       memory: mem_rd_data valid this cycle
//  mem_rd_data    in   DATA_W  memory read word
//  mem_rd_parity  in   1       even-parity bit for mem_rd_data
//  bus_oe         in   1       control unit: drive MDR onto bus
//  bus_data       out  DATA_W  MDR value to bus, 0 when not driving
//  mdr_busy       out  1       high in WAIT
//  mdr_full       out  1       high in FULL
//  rd_timeout     out  1       one-cycle pulse on read abort
//  par_err        out  1       sticky parity error flag
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, mdr=0, timer=0; every output 0.
//  States: IDLE=no data; WAIT=request outstanding; FULL=word held.
//  IDLE: rd_start -> WAIT next edge; timer cleared.
//  WAIT: mem_rd_req=mdr_busy=1 (registered from state). Each edge:
//   - mem_rd_valid=1 -> mdr<=mem_rd_data, -> FULL (valid wins over timeout)
//   - else timer==TIMEOUT_CYC-1 -> IDLE, rd_timeout=1 for one cycle, mdr kept
//   - else timer+1. rd_start ignored in WAIT.
//  FULL: mdr_full=1; holds until mdr_clr (-> IDLE, mdr<=0) or rd_start
//   (-> WAIT, timer cleared, old mdr kept until new capture).
//   mdr_clr and rd_start same edge: mdr_clr wins.
//  mdr_clr in IDLE/WAIT: -> IDLE, mdr<=0, mem_rd_req drops; no rd_timeout.
//  mem_rd_valid outside WAIT: ignored.
//  bus_data = (state==FULL && bus_oe) ? mdr : 0; combinational from state.
//  Latency: valid at edge N -> mdr_full and bus_data valid after edge N.
//  rst asserted mid-WAIT: mem_rd_req drops immediately, no timeout pulse.
// CONFIGURATION
//  MDR_PARITY_EN defined: at capture, (^mem_rd_data ^ mem_rd_parity)!=0 sets
//   par_err; word still captured. par_err cleared only by rst or mdr_clr.
//  Not defined: par_err tied 0; mem_rd_parity unused, port kept.
// STRUCTURE
//  Package mdr_pkg: state enum mdr_state_t (IDLE=2'b00, WAIT=2'b01,
//   FULL=2'b10), MDR_DATA_W=16 default constant.
//  Sub-module mdr_wait_timer: clear/enable counter, $clog2(TIMEOUT_CYC) bits,
//   flags terminal count; all else in top.
// TESTING
//  1 rst pulse mid-run -> all outputs 0, state IDLE, mdr=0 at once.
//  2 rd_start; valid after 3 cycles with 16'h00CF; bus_oe=1 -> mem_rd_req
//    high 3 cycles, mdr_full=1, bus_data=16'h00CF; bus_oe=0 -> bus_data=0.
//  3 rd_start, no valid -> rd_timeout pulse 8 cycles later, IDLE, mdr intact.
//  4 valid on terminal-count cycle with 16'h00AD -> FULL, no rd_timeout.
//  5 FULL + rd_start and mdr_clr same edge -> IDLE, mdr=0, no request.
//  6 MDR_PARITY_EN: data 16'h0001, parity 0 -> par_err=1 stays; mdr_clr
//    clears it. Without macro -> par_err stays 0.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types and defaults for the read-side memory data register.
package mdr_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    FULL = 2'b10
  } mdr_state_t;

  localparam int MDR_DATA_W = 16;
endpackage

// File: rtl/mdr_wait_timer.sv
// Wait-cycle counter for outstanding memory reads; flags the terminal count.
module mdr_wait_timer #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT_CYC - 1));

  // Holds at terminal count; the owner leaves WAIT on that cycle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mdr_in_ctrl.sv
// Read-side MDR: requests a memory word, captures it, drives it onto the bus.
// Optional MDR_PARITY_EN: even-parity check on captured words (sticky par_err).
module mdr_in_ctrl
  import mdr_pkg::*;
#(
  parameter int DATA_W      = MDR_DATA_W,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic              mdr_clr,
  output logic              mem_rd_req,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_parity,
  input  logic              bus_oe,
  output logic [DATA_W-1:0] bus_data,
  output logic              mdr_busy,
  output logic              mdr_full,
  output logic              rd_timeout,
  output logic              par_err
);
  mdr_state_t        state;
  logic [DATA_W-1:0] mdr;
  logic              in_wait;
  logic              not_wait;
  logic              tmr_tc;
  logic              capture;

  assign in_wait  = (state == WAIT);
  assign not_wait = !in_wait;
  assign capture  = in_wait && !mdr_clr && mem_rd_valid;

  mdr_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk (clk),
    .rst (rst),
    .clr (not_wait),
    .en  (in_wait),
    .tc  (tmr_tc)
  );

  assign mem_rd_req = in_wait;
  assign mdr_busy   = in_wait;
  assign mdr_full   = (state == FULL);
  assign bus_data   = (mdr_full && bus_oe) ? mdr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mdr        <= '0;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (mdr_clr)       mdr   <= '0;
          else if (rd_start) state <= WAIT;
        end
        WAIT: begin
          // clear beats capture, capture beats timeout
          if (mdr_clr) begin
            state <= IDLE;
            mdr   <= '0;
          end else if (mem_rd_valid) begin
            state <= FULL;
            mdr   <= mem_rd_data;
          end else if (tmr_tc) begin
            state      <= IDLE;
            rd_timeout <= 1'b1;
          end
        end
        FULL: begin
          if (mdr_clr) begin
            state <= IDLE;
            mdr   <= '0;
          end else if (rd_start) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MDR_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        par_err <= 1'b0;
    else if (mdr_clr)                               par_err <= 1'b0;
    else if (capture && (^mem_rd_data ^ mem_rd_parity)) par_err <= 1'b1;
  end
`else
  logic unused_parity;
  assign unused_parity = mem_rd_parity ^ capture;
  assign par_err       = 1'b0;
`endif
endmodule
